// File: rtl/rob_alloc_ctrl.sv
// rtl/rob_alloc_ctrl.sv - ROB allocation controller: sequence-number issue, free-entry tracking, redirect recovery
module rob_alloc_ctrl #(
   parameter int ID_LEN   = 6,
   parameter int WIDTH_RN = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [$clog2(WIDTH_RN+1)-1:0]    IN_reqCnt,
   input  logic [ID_LEN:0]                  IN_maxSqN,
   input  logic                             IN_branchTaken,
   input  logic [ID_LEN:0]                  IN_branchSqN,
   input  logic                             IN_mispredFlush,
   output logic                             OUT_grant,
   output logic [ID_LEN:0]                  OUT_nextSqN,
   output logic [ID_LEN:0]                  OUT_freeCnt,
   output logic                             OUT_stall,
   output logic                             OUT_recovering
);

   localparam int SQN_W = ID_LEN + 1;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_FLUSH = 2'd1,
      REPLAY     = 2'd2
   } state_t;

   state_t state;

   // Request count widened to SqN width so it can be compared with and added to SqNs
   logic [SQN_W-1:0] reqExt;
   assign reqExt = SQN_W'(IN_reqCnt);

   // Free entries from the ROB's acceptance limit; modular subtraction handles the wrap bit
   always_comb begin
      OUT_freeCnt = IN_maxSqN + SQN_W'(1) - OUT_nextSqN;
   end

   // All-or-nothing grant, only in RUN, never during a redirect or reset cycle
   always_comb begin
      OUT_grant = 1'b0;
      if (!rst && (state == RUN) && !IN_branchTaken &&
          (reqExt != '0) && (reqExt <= OUT_freeCnt))
         OUT_grant = 1'b1;
      OUT_stall = (reqExt != '0) && !OUT_grant;
   end

   // Recovery FSM and SqN counter; a redirect in any state restarts recovery
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= RUN;
         OUT_nextSqN    <= '0;
         OUT_recovering <= 1'b0;
      end else if (IN_branchTaken) begin
         state          <= WAIT_FLUSH;
         OUT_nextSqN    <= IN_branchSqN + SQN_W'(1);
         OUT_recovering <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (OUT_grant)
                  OUT_nextSqN <= OUT_nextSqN + reqExt;
            end
            WAIT_FLUSH: begin
               if (IN_mispredFlush)
                  state <= REPLAY;
            end
            REPLAY: begin
               if (!IN_mispredFlush) begin
                  state          <= RUN;
                  OUT_recovering <= 1'b0;
               end
            end
            default: begin
               state          <= RUN;
               OUT_recovering <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb/tb_rob_alloc_ctrl.sv - randomized and directed bench for rob_alloc_ctrl against a behavioural model
module tb_rob_alloc_ctrl;

   logic       clk;
   logic       rst;
   logic [2:0] reqCnt;
   logic [6:0] maxSqN;
   logic       branchTaken;
   logic [6:0] branchSqN;
   logic       mispredFlush;
   logic       grant;
   logic [6:0] nextSqN;
   logic [6:0] freeCnt;
   logic       stall;
   logic       recovering;

   rob_alloc_ctrl #(.ID_LEN(6), .WIDTH_RN(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .IN_reqCnt       (reqCnt),
      .IN_maxSqN       (maxSqN),
      .IN_branchTaken  (branchTaken),
      .IN_branchSqN    (branchSqN),
      .IN_mispredFlush (mispredFlush),
      .OUT_grant       (grant),
      .OUT_nextSqN     (nextSqN),
      .OUT_freeCnt     (freeCnt),
      .OUT_stall       (stall),
      .OUT_recovering  (recovering)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;
   int nGrant      = 0;

   // Reference model: next SqN as an integer mod 128, plus recovery progress flags
   int mNext;
   bit mRec;
   bit mFlushSeen;

   task automatic chk(input string tag, input int obs, input int exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, check combinational/registered outputs, then advance the model
   task automatic step(input bit r, input int req, input int mx,
                       input bit bt, input int bs, input bit mf);
      int free;
      bit g;
      bit s;
      @(negedge clk);
      rst          = r;
      reqCnt       = 3'(req);
      maxSqN       = 7'(mx);
      branchTaken  = bt;
      branchSqN    = 7'(bs);
      mispredFlush = mf;
      free = (mx + 1 - mNext + 256) % 128;
      g = !r && !mRec && !bt && (req > 0) && (req <= free);
      s = (req > 0) && !g;
      #1;
      chk("grant",      int'(grant),      int'(g));
      chk("stall",      int'(stall),      int'(s));
      chk("freeCnt",    int'(freeCnt),    free);
      chk("nextSqN",    int'(nextSqN),    mNext);
      chk("recovering", int'(recovering), int'(mRec));
      if (grant === 1'b1) nGrant++;
      @(posedge clk);
      #1;
      if (r) begin
         mNext = 0; mRec = 0; mFlushSeen = 0;
      end else if (bt) begin
         mNext = (bs + 1) % 128; mRec = 1; mFlushSeen = 0;
      end else if (mRec) begin
         if (!mFlushSeen && mf) mFlushSeen = 1;
         else if (mFlushSeen && !mf) begin mRec = 0; mFlushSeen = 0; end
      end else if (g) begin
         mNext = (mNext + req) % 128;
      end
   endtask

   initial begin
      int mx;
      rst = 1'b1; reqCnt = '0; maxSqN = 7'd63;
      branchTaken = 1'b0; branchSqN = '0; mispredFlush = 1'b0;
      mNext = 0; mRec = 0; mFlushSeen = 0;
      @(posedge clk); #1;

      // Reset state
      step(1, 0, 63, 0, 0, 0);
      step(0, 0, 63, 0, 0, 0);
      chk("rst_nextSqN", int'(nextSqN), 0);
      chk("rst_freeCnt", int'(freeCnt), 64);
      chk("rst_stall",   int'(stall),   0);
      chk("rst_recov",   int'(recovering), 0);

      // Fill the ROB in groups of four until full
      nGrant = 0;
      for (int i = 0; i < 16; i++) step(0, 4, 63, 0, 0, 0);
      chk("fill_grants",  nGrant, 16);
      chk("fill_nextSqN", int'(nextSqN), 64);
      chk("fill_freeCnt", int'(freeCnt), 0);
      chk("fill_stall",   int'(stall), 1);
      step(0, 4, 63, 0, 0, 0);

      // Wrap of the SqN counter, stall then exactly-fits grant
      for (int i = 0; i < 15; i++) step(0, 4, 127, 0, 0, 0);
      chk("pre_wrap_nextSqN", int'(nextSqN), 124);
      step(0, 4, 126, 0, 0, 0);
      chk("short_freeCnt", int'(freeCnt), 3);
      chk("short_stall",   int'(stall), 1);
      step(0, 4, 127, 0, 0, 0);
      chk("wrap_nextSqN", int'(nextSqN), 0);

      // Redirect, flush window, resume
      step(0, 2, 63, 1, 20, 0);
      chk("redir_nextSqN", int'(nextSqN), 21);
      chk("redir_recov",   int'(recovering), 1);
      for (int i = 0; i < 3; i++) step(0, 2, 63, 0, 0, 1);
      step(0, 2, 63, 0, 0, 0);
      chk("resume_recov", int'(recovering), 0);
      chk("resume_grant", int'(grant), 1);
      step(0, 2, 63, 0, 0, 0);

      // Redirect during replay restarts recovery
      step(0, 1, 63, 1, 30, 0);
      step(0, 1, 63, 0, 0, 1);
      step(0, 1, 63, 1, 10, 1);
      chk("rerdir_nextSqN", int'(nextSqN), 11);
      chk("rerdir_recov",   int'(recovering), 1);
      step(0, 1, 63, 0, 0, 1);
      step(0, 1, 63, 0, 0, 0);
      step(0, 1, 63, 0, 0, 0);

      // Reset wins over a redirect in replay
      step(0, 1, 63, 1, 40, 0);
      step(0, 1, 63, 0, 0, 1);
      step(1, 1, 63, 1, 5, 1);
      chk("rstrep_nextSqN", int'(nextSqN), 0);
      chk("rstrep_recov",   int'(recovering), 0);
      step(0, 1, 63, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) mx = $urandom_range(0, 127);
         else mx = (mNext + int'($urandom_range(0, 9)) - 1 + 128) % 128;
         step(($urandom_range(0, 199) == 0),
              int'($urandom_range(0, 4)),
              mx,
              ($urandom_range(0, 15) == 0),
              int'($urandom_range(0, 127)),
              ($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
